// File: rtl/vram_arbiter.sv
// VRAM arbiter: the scanout owns the RAM in the visible area; CPU writes are
// buffered in a FIFO and drained in blanking, and CPU reads are served after the drain.
module vram_arbiter #(
   parameter int AW     = 19,
   parameter int DW     = 8,
   parameter int WDEPTH = 4
) (
   input  logic                       pclk,
   input  logic                       reset_n,
   input  logic                       vid_active,
   input  logic [AW-1:0]              vid_addr,
   output logic [DW-1:0]              vid_data,
   input  logic                       cpu_req,
   input  logic                       cpu_we,
   input  logic [AW-1:0]              cpu_addr,
   input  logic [DW-1:0]              cpu_wdata,
   output logic                       cpu_ack,
   output logic [DW-1:0]              cpu_rdata,
   output logic [$clog2(WDEPTH):0]    fifo_level,
   output logic [AW-1:0]              ram_addr,
   output logic                       ram_we,
   output logic [DW-1:0]              ram_wdata,
   input  logic [DW-1:0]              ram_rdata
);

   localparam int PW = $clog2(WDEPTH);
   localparam int LW = PW + 1;

   typedef enum logic [1:0] {
      IDLE,
      RD_PEND,
      RD_DATA
   } rd_state_t;

   rd_state_t state, state_d;

   logic [AW-1:0] fa_mem [WDEPTH];
   logic [DW-1:0] fd_mem [WDEPTH];
   logic [PW-1:0] wptr, rptr;
   logic [LW-1:0] level;
   logic [AW-1:0] rd_addr;

   logic empty, full, pop, push, rd_go, rd_issue;

   assign empty    = (level == '0);
   assign full     = (level == LW'(WDEPTH));
   assign pop      = !vid_active && !empty;
   // A pop in the same cycle frees the slot the new write lands in.
   assign push     = cpu_req && cpu_we && !cpu_ack
                     && (state == IDLE) && (!full || pop);
   assign rd_go    = cpu_req && !cpu_we && !cpu_ack
                     && (state == IDLE) && empty;
   assign rd_issue = (state == RD_PEND) && !vid_active && empty;

   assign fifo_level = level;
   assign vid_data   = ram_rdata;

   always_ff @(posedge pclk) begin
      if (push) begin
         fa_mem[wptr] <= cpu_addr;
         fd_mem[wptr] <= cpu_wdata;
      end
   end

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);
         unique case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:    if (rd_go) state_d = RD_PEND;
         RD_PEND: if (rd_issue) state_d = RD_DATA;
         RD_DATA: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         rd_addr   <= '0;
         cpu_ack   <= 1'b0;
         cpu_rdata <= '0;
      end else begin
         if (rd_go) rd_addr <= cpu_addr;
         cpu_ack <= push || (state == RD_DATA);
         if (state == RD_DATA) cpu_rdata <= ram_rdata;
      end
   end

   always_comb begin
      ram_addr  = vid_addr;
      ram_we    = 1'b0;
      ram_wdata = fd_mem[rptr];
      unique case (1'b1)
         pop: begin
            ram_addr = fa_mem[rptr];
            ram_we   = 1'b1;
         end
         rd_issue: ram_addr = rd_addr;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: expected acks and RAM writes are queued
// at issue time and checked by a negedge monitor.
module tb_vram_arbiter;

   logic        pclk = 1'b0;
   logic        reset_n;
   logic        vid_active;
   logic [18:0] vid_addr;
   logic [7:0]  vid_data;
   logic        cpu_req, cpu_we;
   logic [18:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;
   logic [2:0]  fifo_level;
   logic [18:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;

   always #5 pclk = ~pclk;

   vram_arbiter #(.AW(19), .DW(8), .WDEPTH(4)) dut (
      .pclk(pclk), .reset_n(reset_n),
      .vid_active(vid_active), .vid_addr(vid_addr), .vid_data(vid_data),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .fifo_level(fifo_level), .ram_addr(ram_addr), .ram_we(ram_we),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   // Unwritten locations read back as their address low byte.
   logic [7:0] mem [logic [18:0]];
   always @(posedge pclk) begin
      logic [7:0] rd;
      rd = mem.exists(ram_addr) ? mem[ram_addr] : ram_addr[7:0];
      if (ram_we) mem[ram_addr] = ram_wdata;
      ram_rdata <= rd;
   end

   typedef struct {
      bit         rd;
      logic [7:0] d;
   } ack_t;

   ack_t        ackq [$];
   logic [26:0] wrq  [$];
   int checks = 0;
   int errors = 0;
   int acks_seen = 0;
   bit scan_on = 0;
   bit prev_ok = 0;
   logic [18:0] prev_addr = '0;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", n, a, e, $time);
      end
   endtask

   always @(negedge pclk) begin
      ack_t        ea;
      logic [26:0] ew;
      if (reset_n) begin
         if (cpu_ack) begin
            acks_seen++;
            if (ackq.size() == 0) begin
               chk("unexpected_ack", 32'(cpu_ack), 32'd0);
            end else begin
               ea = ackq.pop_front();
               chk("ack_kind", 32'(cpu_we), 32'(!ea.rd));
               if (ea.rd) chk("rd_data", 32'(cpu_rdata), 32'(ea.d));
            end
         end
         if (ram_we) begin
            if (wrq.size() == 0) begin
               chk("stale_ram_we", 32'(ram_we), 32'd0);
            end else begin
               ew = wrq.pop_front();
               chk("wr_addr", 32'(ram_addr), 32'(ew[26:8]));
               chk("wr_data", 32'(ram_wdata), 32'(ew[7:0]));
            end
         end
         if (vid_active) chk("we_in_active", 32'(ram_we), 32'd0);
         if (scan_on && prev_ok)
            chk("scan_data", 32'(vid_data), 32'(prev_addr[7:0]));
         prev_ok   = scan_on && vid_active;
         prev_addr = vid_addr;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   task automatic cpu_write(input logic [18:0] a, input logic [7:0] d,
                            input bit to_ram, output int waited);
      ackq.push_back('{rd: 1'b0, d: 8'h00});
      if (to_ram) wrq.push_back({a, d});
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
      waited = 0;
      do begin
         @(negedge pclk);
         waited++;
      end while (!cpu_ack && waited < 400);
      if (!cpu_ack) chk("write_timeout", 32'(cpu_ack), 32'd1);
      tick(1);
      cpu_req = 1'b0;
   endtask

   task automatic cpu_read(input logic [18:0] a, input logic [7:0] d);
      int waited;
      ackq.push_back('{rd: 1'b1, d: d});
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
      waited = 0;
      do begin
         @(negedge pclk);
         waited++;
      end while (!cpu_ack && waited < 400);
      if (!cpu_ack) chk("read_timeout", 32'(cpu_ack), 32'd1);
      tick(1);
      cpu_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int a0;
      logic [2:0] bits;
      reset_n = 1'b0; vid_active = 1'b0; vid_addr = '0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      tick(3);
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_ack", 32'(cpu_ack), 32'd0);
      chk("rst_we", 32'(ram_we), 32'd0);
      chk("rst_rdata", 32'(cpu_rdata), 32'd0);
      reset_n = 1'b1;
      tick(2);

      // scanout only
      vid_active = 1'b1;
      scan_on = 1'b1;
      for (int i = 0; i < 640; i++) begin
         vid_addr = 19'(i);
         tick(1);
      end
      scan_on = 1'b0;

      // write in blanking
      vid_active = 1'b0;
      cpu_write(19'h00100, 8'h2A, 1'b1, w);
      chk("wr_ack_latency", 32'(w), 32'd2);
      tick(2);
      chk("wr_level_zero", 32'(fifo_level), 32'd0);

      // FIFO full during visible area
      vid_active = 1'b1;
      a0 = acks_seen;
      fork
         begin
            for (int i = 0; i < 5; i++)
               cpu_write(19'h00200 + 19'(i), 8'h10 + 8'(i), 1'b1, w);
         end
         begin
            tick(20);
            chk("full_level", 32'(fifo_level), 32'd4);
            chk("full_acks", 32'(acks_seen - a0), 32'd4);
            chk("full_held", 32'(cpu_req), 32'd1);
            vid_active = 1'b0;
            @(negedge pclk);
            chk("first_pop", 32'(ram_we), 32'd1);
            chk("fifth_not_yet", 32'(cpu_ack), 32'd0);
            @(negedge pclk);
            chk("fifth_ack", 32'(cpu_ack), 32'd1);
            chk("fifth_level", 32'(fifo_level), 32'd4);
         end
      join
      tick(10);
      chk("drain_level", 32'(fifo_level), 32'd0);

      // read after write
      vid_active = 1'b1;
      cpu_write(19'h01234, 8'h55, 1'b1, w);
      fork
         cpu_read(19'h01234, 8'h55);
         begin
            tick(10);
            chk("raw_pending", 32'(fifo_level), 32'd1);
            vid_active = 1'b0;
         end
      join
      tick(3);

      // read in visible area
      vid_active = 1'b1;
      fork
         cpu_read(19'h00345, 8'h45);
         begin
            tick(100);
            vid_active = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge pclk);
               bits[k] = cpu_ack;
            end
            chk("rd_ack_timing", 32'(bits), 32'b100);
         end
      join
      tick(3);

      // reset with three buffered writes
      vid_active = 1'b1;
      for (int i = 0; i < 3; i++)
         cpu_write(19'h00400 + 19'(i), 8'hA0 + 8'(i), 1'b0, w);
      chk("pre_rst_level", 32'(fifo_level), 32'd3);
      reset_n = 1'b0;
      #1;
      chk("rstA_level", 32'(fifo_level), 32'd0);
      chk("rstA_ack", 32'(cpu_ack), 32'd0);
      chk("rstA_we", 32'(ram_we), 32'd0);
      chk("rstA_rdata", 32'(cpu_rdata), 32'd0);
      tick(2);
      reset_n = 1'b1;
      vid_active = 1'b0;
      tick(20);

      // reset with a read pending
      vid_active = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00777;
      tick(5);
      reset_n = 1'b0;
      #1;
      chk("rstB_ack", 32'(cpu_ack), 32'd0);
      chk("rstB_we", 32'(ram_we), 32'd0);
      cpu_req = 1'b0;
      tick(2);
      reset_n = 1'b1;
      vid_active = 1'b0;
      tick(10);

      chk("ackq_empty", 32'(ackq.size()), 32'd0);
      chk("wrq_empty", 32'(wrq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port video RAM between the VGA scanout and the CPU bus. During the visible area the scanout owns the RAM every clock. CPU writes are buffered in a small FIFO and drained in blanking cycles. CPU reads are queued behind pending writes and served in the first free cycle. The block sits between the 640x480 pixel controller (address/data pair) and the Z80 memory decode.

## Interface
Parameters:
- AW, 19, RAM address width (matches the pixel address width)
- DW, 8, RAM data width (one RRGGBB pixel byte)
- WDEPTH, 4, CPU write FIFO depth (power of two, 2..16)

Ports:
- pclk  in  1  pixel clock; sole clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- vid_active  in  1  high when scanout owns the RAM this cycle (visible area)
- vid_addr  in  AW  scanout pixel address
- vid_data  out  DW  pixel byte for the vid_addr presented one cycle earlier
- cpu_req  in  1  CPU request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_ack  out  1  one-cycle acknowledge (write accepted / read data valid)
- cpu_rdata  out  DW  read data, valid while cpu_ack is high, held afterwards
- fifo_level  out  $clog2(WDEPTH)+1  write FIFO occupancy
- ram_addr  out  AW  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, synchronous, one-cycle latency

## Operation
- **RAM mux (combinational):**
  - When vid_active is high: ram_addr = vid_addr, ram_we = 0.
  - Otherwise the CPU slot drives the RAM. Priority: FIFO pop (write), then pending read. With neither: ram_we = 0 and ram_addr = vid_addr.
  - vid_data = ram_rdata, passed through unregistered.
- **Write acceptance:** an edge where cpu_req=1, cpu_we=1, FIFO not full and cpu_ack=0 pushes {cpu_addr, cpu_wdata}. cpu_ack is high the following cycle.
- **Re-acceptance guard:** cpu_req is ignored in any cycle where cpu_ack is high, so one held request is never accepted twice.
- **Write drain:** in any cycle with vid_active=0 and the FIFO non-empty, the head entry drives ram_addr/ram_wdata with ram_we=1 and is popped at the edge.
- **Simultaneous push and pop:** fifo_level is unchanged; pointers wrap modulo WDEPTH.
- **Read FSM:**
  - IDLE: on cpu_req=1, cpu_we=0, cpu_ack=0, FIFO empty, latch cpu_addr and go to RD_PEND. If the FIFO is not empty the read is not accepted; it waits until the FIFO drains, which preserves read-after-write ordering.
  - RD_PEND: in the first cycle with vid_active=0 and FIFO empty, drive ram_addr = latched address, ram_we = 0, go to RD_DATA. While vid_active=1, stay in RD_PEND.
  - RD_DATA: register ram_rdata into cpu_rdata, assert cpu_ack for one cycle, return to IDLE.
- **Writes during a pending read:** not accepted (cpu_we is stable for the one outstanding request). Only one CPU transaction is outstanding at a time.
- **Full FIFO:** a write request is held with cpu_ack=0 until a pop frees a slot. Accepting into a slot freed by a pop in the same cycle is allowed.
- **Reset, asynchronous and any time:**
  - FIFO emptied, pointers 0, fifo_level 0.
  - FSM returns to IDLE and any pending read is dropped without an ack.
  - cpu_ack 0, cpu_rdata 0, ram_we 0.

## Timing
- Scanout latency: vid_addr at cycle n → vid_data valid at cycle n+1. Never stalled.
- Write ack latency: 1 cycle after acceptance, independent of vid_active.
- Write-to-RAM latency: acceptance at n with vid_active=0 and FIFO empty → ram_we at n+1 at the earliest.
- Read latency, blanking and FIFO empty: req at edge n → RD_PEND at n+1 (RAM read issued) → cpu_ack at n+2.
- Read latency during visible area: extends by the number of remaining vid_active cycles (up to 640 plus drain cycles).
- The CPU never preempts the scanout; ram_we is 0 in every cycle with vid_active=1.

## Test plan
- **Scanout only:** vid_active=1, vid_addr stepping 0..639, RAM preloaded with addr[7:0] → vid_data equals the previous-cycle address low byte every cycle; ram_we never asserts.
- **Write in blanking:** vid_active=0, write 0x2A to 0x00100 → cpu_ack one cycle later. ram_we=1 with ram_addr=0x00100 and ram_wdata=0x2A exactly once; fifo_level returns to 0.
- **FIFO full during visible area:** vid_active=1, five back-to-back writes → four acks, fifo_level=4, fifth req held without ack. Drop vid_active → four RAM writes in order, fifth accepted on the first pop cycle.
- **Read-after-write:** write 0x55 to 0x01234 during vid_active=1, then read 0x01234 → read waits for the drain; cpu_rdata=0x55 with cpu_ack.
- **Read in visible area:** read issued with vid_active=1 for 100 more cycles → no RAM read until vid_active=0; cpu_ack exactly 2 cycles after vid_active falls.
- **Reset mid-operation:** reset_n low while fifo_level=3 and a read is in RD_PEND → fifo_level=0, cpu_ack=0, ram_we=0 immediately; no stale writes after reset release.
